mini_cpu_param: RTL and testbench
=================================

// Module: mini_cpu_param
// PURPOSE
//  Parametrised successor of the mini CPU controller: same power-on/LCD-clear/fetch-decode-execute-writeback flow.
//  Adds generic data/register/immediate widths, an internal register file, 2-flop key synchronisers,
//  a programmable LCD_E pulse and a busy flag. Sits between board keys/switches, the external ALU and the LCD.
// PARAMETERS
//  DATA_W      16     register/ALU operand width (>=8)
//  RA_W        4      register address width; register file has 2**RA_W entries
//  IMM_W       6      immediate magnitude width; INSTR_W = 3+2*RA_W+1+IMM_W (18 at defaults)
//  DELAY       50000  cycles spent in INIT, LCD_CLEAR and SPECIAL (>=2)
//  LCD_E_CYC   4      cycles lcd_e is held high per LCD write (1..DELAY)
// PORTS
//  clk                 in   1        system clock
//  reset               in   1        asynchronous, active-low reset
//  key_ligar           in   1        power key, active-low press, asynchronous
//  key_enviar          in   1        submit key, active-low press, asynchronous
//  instruction_input   in   INSTR_W  instruction word, sampled on submit
//  alu_result          in   DATA_W   signed result from external combinational ALU
//  alu_op              out  3        ALU operation (= opcode for 001..101, else 000)
//  alu_op_a, alu_op_b  out  DATA_W   signed ALU operands
//  LED_vermelho        out  1        high in OFF
//  LED_verde           out  1        high in INIT and FETCH
//  lcd_data_bus        out  8        LCD data/command
//  lcd_rs, lcd_rw, lcd_e  out 1 each  LCD control; lcd_rw always 0
//  busy                out  1        high in every state except OFF and FETCH
// BEHAVIOUR
//  Reset: state OFF, instr reg, counters, key syncs and all register-file entries to 0; outputs: LED_vermelho=1, all else 0.
//  Keys: each through 2-flop sync + prev flop; press event = synced 1->0 transition (3-cycle detect latency).
//  Instruction format, MSB first: opcode[3].
//   R (001 ADD, 011 SUB): opcode, pad, rd, rs1, rs2 in lowest 3*RA_W bits.
//   I (010 ADDI, 100 SUBI, 101 MULI): opcode, rd, rs1, sign, imm.
//   LOAD 000: opcode, pad, rd, sign, imm. CLEAR 110: no fields. DISPLAY 111: rs1 in lowest RA_W bits.
//  Immediate = sign-extended {sign, imm} to DATA_W (sign=1 replicates 1s; two's-complement value).
//  FSM: OFF -ligar-> INIT -DELAY cyc-> LCD_CLEAR -DELAY cyc-> FETCH.
//   FETCH: ligar -> OFF; else enviar -> latch instruction_input, DECODE. Both in same cycle: ligar wins.
//   DECODE (1 cyc): 000 -> WRITEBACK; 110/111 -> SPECIAL; else EXECUTE.
//   EXECUTE (1 cyc) -> WRITEBACK (1 cyc) -> FETCH.
//   SPECIAL: DELAY cyc -> FETCH. Key events outside OFF/FETCH ignored (not queued).
//  Timed states exit after exactly DELAY cycles; counter cleared on every state entry.
//  Operands: alu_op_a = rf[rs1] in EXECUTE/WRITEBACK; alu_op_b = rf[rs2] (R) or immediate (I); 0 elsewhere.
//  Register file: async read, sync write on WRITEBACK clock edge: rd <= LOAD ? immediate : alu_result.
//  Arithmetic wraps at DATA_W; no overflow detection. CLEAR zeroes all entries on first SPECIAL cycle.
//  LCD writes:
//   LCD_CLEAR: data 8'h01, rs=0.
//   WRITEBACK: written value[7:0], rs=1, held LCD_E_CYC cycles (into FETCH).
//   SPECIAL/CLEAR: 8'h43, rs=1. SPECIAL/DISPLAY: rf[rs1][7:0], rs=1.
//   lcd_e high for first LCD_E_CYC cycles of each write; data/rs stable throughout.
//   A new FETCH submit during an active pulse is accepted but its DECODE waits until the pulse ends.
//  Reset mid-operation: immediate return to reset state; no partial write completes.
// CONFIGURATION
//  MINI_CPU_FLAGS_EN defined: adds outputs flag_zero, flag_neg (1 bit each), reset 0, updated on every WRITEBACK
//   from the written value (==0, MSB); CLEAR zeroes both. Undefined: ports absent, no flag logic.
// TESTING
//  Reset then ligar press -> LED_verde after 3 cyc; lcd_e with 8'h01 DELAY cyc later; FETCH after 2*DELAY.
//  LOAD r2,-5 then DISPLAY r2 -> rf[2]=16'hFFFB; lcd_data_bus=8'hFB, rs=1 in SPECIAL.
//  LOAD r1,7; LOAD r3,9; ADD r4,r1,r3 -> alu_op=001, a=7, b=9; ALU returns 16 -> rf[4]=16, LCD 8'h10.
//  CLEAR after loads -> all regs 0, LCD 8'h43 for LCD_E_CYC cyc, back to FETCH after DELAY.
//  ligar and enviar pressed same cycle in FETCH -> OFF, LED_vermelho=1, instruction not latched.
//  reset low during SPECIAL/WRITEBACK -> next cycle state OFF, rf all 0, outputs at reset values.

Source files
------------

// File: rtl/mini_cpu_param.sv
// Parametrised mini CPU controller: keys/switches in, external ALU operands out, LCD writes with a timed E pulse.
// Define MINI_CPU_FLAGS_EN to add the flag_zero/flag_neg outputs that track the last written value.
module mini_cpu_param #(
  parameter int DATA_W    = 16,
  parameter int RA_W      = 4,
  parameter int IMM_W     = 6,
  parameter int DELAY     = 50000,
  parameter int LCD_E_CYC = 4,
  localparam int INSTR_W  = 3 + 2*RA_W + 1 + IMM_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_ligar,
  input  logic                     key_enviar,
  input  logic [INSTR_W-1:0]       instruction_input,
  input  logic signed [DATA_W-1:0] alu_result,
  output logic [2:0]               alu_op,
  output logic signed [DATA_W-1:0] alu_op_a,
  output logic signed [DATA_W-1:0] alu_op_b,
  output logic                     LED_vermelho,
  output logic                     LED_verde,
  output logic [7:0]               lcd_data_bus,
  output logic                     lcd_rs,
  output logic                     lcd_rw,
  output logic                     lcd_e,
  output logic                     busy,
  output logic [2:0]               dbg_state_o
`ifdef MINI_CPU_FLAGS_EN
  ,
  output logic                     flag_zero,
  output logic                     flag_neg
`endif
);

  typedef enum logic [2:0] {
    S_OFF, S_INIT, S_LCD_CLR, S_FETCH, S_DECODE, S_EXEC, S_WB, S_SPECIAL
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000, OP_ADD  = 3'b001, OP_ADDI  = 3'b010, OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100, OP_MULI = 3'b101, OP_CLEAR = 3'b110;

  localparam int CNT_W = $clog2(DELAY + 1);
  localparam int E_W   = $clog2(LCD_E_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);
  localparam logic [E_W-1:0]   E_LOAD   = E_W'(LCD_E_CYC);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [E_W-1:0]       e_cnt_q, e_cnt_d;
  logic [7:0]           lcd_data_q, lcd_data_d;
  logic                 lcd_rs_q, lcd_rs_d;
  logic                 lig_s1_q, lig_s2_q, lig_prev_q;
  logic                 env_s1_q, env_s2_q, env_prev_q;
  logic [DATA_W-1:0]    rf_q [2**RA_W];

  // Keys idle high; a press is a synchronised high-to-low transition.
  logic lig_ev, env_ev;
  assign lig_ev = lig_prev_q & ~lig_s2_q;
  assign env_ev = env_prev_q & ~env_s2_q;

  logic [2:0]        opcode;
  logic              is_r, is_i, is_alu, timed, timer_done, op_active, rf_we, rf_clr;
  logic [RA_W-1:0]   rs1, rs2, rd, disp_rs;
  logic [DATA_W-1:0] imm_val, wb_val;

  assign opcode  = instr_q[INSTR_W-1 -: 3];
  assign is_r    = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_i    = (opcode == OP_ADDI) || (opcode == OP_SUBI) || (opcode == OP_MULI);
  assign is_alu  = is_r || is_i;
  assign rs2     = instr_q[RA_W-1:0];
  assign disp_rs = instr_q[RA_W-1:0];
  assign rs1     = is_r ? instr_q[2*RA_W-1:RA_W] : instr_q[IMM_W+RA_W:IMM_W+1];
  assign rd      = is_r ? instr_q[3*RA_W-1:2*RA_W]
                 : (is_i ? instr_q[IMM_W+2*RA_W:IMM_W+RA_W+1] : instr_q[IMM_W+RA_W:IMM_W+1]);
  assign imm_val = {{(DATA_W-IMM_W-1){instr_q[IMM_W]}}, instr_q[IMM_W:0]};
  assign wb_val  = (opcode == OP_LOAD) ? imm_val : alu_result;

  assign op_active  = ((state_q == S_EXEC) || (state_q == S_WB)) && is_alu;
  assign alu_op     = is_alu ? opcode : 3'b000;
  assign alu_op_a   = op_active ? rf_q[rs1] : '0;
  assign alu_op_b   = op_active ? (is_r ? rf_q[rs2] : imm_val) : '0;

  assign timed      = (state_q == S_INIT) || (state_q == S_LCD_CLR) || (state_q == S_SPECIAL);
  assign timer_done = (cnt_q == CNT_LAST);
  assign rf_we      = (state_q == S_WB);
  assign rf_clr     = (state_q == S_SPECIAL) && (cnt_q == '0) && (opcode == OP_CLEAR);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    e_cnt_d    = (e_cnt_q != '0) ? e_cnt_q - 1'b1 : '0;
    case (state_q)
      S_OFF:     if (lig_ev) state_d = S_INIT;
      S_INIT:    if (timer_done) state_d = S_LCD_CLR;
      S_LCD_CLR: if (timer_done) state_d = S_FETCH;
      S_FETCH: begin
        if (lig_ev) begin
          state_d = S_OFF;
        end else if (env_ev) begin
          state_d = S_DECODE;
          instr_d = instruction_input;
        end
      end
      // Hold here while a writeback pulse is still on the LCD.
      S_DECODE: begin
        if (e_cnt_q == '0) begin
          if (opcode == OP_LOAD)    state_d = S_WB;
          else if (opcode[2:1] == 2'b11) state_d = S_SPECIAL;
          else                      state_d = S_EXEC;
        end
      end
      S_EXEC:    state_d = S_WB;
      S_WB:      state_d = S_FETCH;
      S_SPECIAL: if (timer_done) state_d = S_FETCH;
      default:   state_d = S_OFF;
    endcase

    cnt_d = (state_d != state_q) ? '0 : (timed ? cnt_q + 1'b1 : '0);

    // LCD writes launch on the edge that enters their state.
    if (state_d != state_q) begin
      case (state_d)
        S_OFF: begin
          lcd_data_d = 8'h00; lcd_rs_d = 1'b0; e_cnt_d = '0;
        end
        S_LCD_CLR: begin
          lcd_data_d = 8'h01; lcd_rs_d = 1'b0; e_cnt_d = E_LOAD;
        end
        S_WB: begin
          lcd_data_d = wb_val[7:0]; lcd_rs_d = 1'b1; e_cnt_d = E_LOAD;
        end
        S_SPECIAL: begin
          lcd_data_d = (opcode == OP_CLEAR) ? 8'h43 : rf_q[disp_rs][7:0];
          lcd_rs_d   = 1'b1;
          e_cnt_d    = E_LOAD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      instr_q    <= '0;
      e_cnt_q    <= '0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lig_s1_q   <= 1'b0; lig_s2_q <= 1'b0; lig_prev_q <= 1'b0;
      env_s1_q   <= 1'b0; env_s2_q <= 1'b0; env_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      e_cnt_q    <= e_cnt_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lig_s1_q   <= key_ligar;  lig_s2_q <= lig_s1_q; lig_prev_q <= lig_s2_q;
      env_s1_q   <= key_enviar; env_s2_q <= env_s1_q; env_prev_q <= env_s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**RA_W; i++) rf_q[i] <= '0;
    end else if (rf_clr) begin
      for (int i = 0; i < 2**RA_W; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= wb_val;
    end
  end

`ifdef MINI_CPU_FLAGS_EN
  logic flag_zero_q, flag_neg_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
    end else if (rf_clr) begin
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
    end else if (rf_we) begin
      flag_zero_q <= (wb_val == '0);
      flag_neg_q  <= wb_val[DATA_W-1];
    end
  end
  assign flag_zero = flag_zero_q;
  assign flag_neg  = flag_neg_q;
`endif

  assign LED_vermelho = (state_q == S_OFF);
  assign LED_verde    = (state_q == S_INIT) || (state_q == S_FETCH);
  assign busy         = (state_q != S_OFF) && (state_q != S_FETCH);
  assign lcd_data_bus = lcd_data_q;
  assign lcd_rs       = lcd_rs_q;
  assign lcd_rw       = 1'b0;
  assign lcd_e        = (e_cnt_q != '0);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mini_cpu_param.sv
// Directed bench for mini_cpu_param: LCD writes are checked by a scoreboard monitor, timing and operands inline.
module tb_mini_cpu_param;
  localparam int DATA_W    = 16;
  localparam int RA_W      = 4;
  localparam int IMM_W     = 6;
  localparam int DELAY     = 8;
  localparam int LCD_E_CYC = 3;
  localparam int INSTR_W   = 18;

  logic               clk = 1'b0;
  logic               reset;
  logic               key_ligar, key_enviar;
  logic [INSTR_W-1:0] instruction_input;
  logic [DATA_W-1:0]  alu_result;
  logic [2:0]         alu_op;
  logic [DATA_W-1:0]  alu_op_a, alu_op_b;
  logic               LED_vermelho, LED_verde;
  logic [7:0]         lcd_data_bus;
  logic               lcd_rs, lcd_rw, lcd_e, busy;
  logic [2:0]         dbg_state;
`ifdef MINI_CPU_FLAGS_EN
  logic               flag_zero, flag_neg;
`endif

  mini_cpu_param #(
    .DATA_W(DATA_W), .RA_W(RA_W), .IMM_W(IMM_W), .DELAY(DELAY), .LCD_E_CYC(LCD_E_CYC)
  ) dut (
    .clk(clk), .reset(reset), .key_ligar(key_ligar), .key_enviar(key_enviar),
    .instruction_input(instruction_input), .alu_result(alu_result),
    .alu_op(alu_op), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .LED_vermelho(LED_vermelho), .LED_verde(LED_verde),
    .lcd_data_bus(lcd_data_bus), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .busy(busy), .dbg_state_o(dbg_state)
`ifdef MINI_CPU_FLAGS_EN
    , .flag_zero(flag_zero), .flag_neg(flag_neg)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // external ALU model
  always_comb begin
    case (alu_op)
      3'b001, 3'b010: alu_result = alu_op_a + alu_op_b;
      3'b011, 3'b100: alu_result = alu_op_a - alu_op_b;
      3'b101:         alu_result = alu_op_a * alu_op_b;
      default:        alu_result = '0;
    endcase
  end

  // scoreboard: expected LCD writes as {rs, data}
  logic [8:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic       e_prev = 1'b0;
  int         e_len  = 0;
  logic [8:0] e_exp;
  always @(negedge clk) begin
    if (!reset) begin
      e_prev = 1'b0;
      e_len  = 0;
    end else begin
      if (lcd_e && !e_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL lcd_unexpected: got rs=%0b data=%0h, expected no write", lcd_rs, lcd_data_bus);
        end else begin
          e_exp = exp_q.pop_front();
          check("lcd_write", {23'b0, lcd_rs, lcd_data_bus}, {23'b0, e_exp});
        end
        e_len = 1;
      end else if (lcd_e) begin
        e_len++;
      end else if (e_prev) begin
        check("lcd_e_width", e_len, LCD_E_CYC);
      end
      e_prev = lcd_e;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] enc_load(input logic [3:0] rd, input logic [6:0] v);
    return {3'b000, 4'b0000, rd, v};
  endfunction
  function automatic logic [17:0] enc_r(input logic [2:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, 3'b000, rd, rs1, rs2};
  endfunction
  function automatic logic [17:0] enc_i(input logic [2:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [6:0] v);
    return {op, rd, rs1, v};
  endfunction
  function automatic logic [17:0] enc_disp(input logic [3:0] rs);
    return {3'b111, 11'b0, rs};
  endfunction

  task automatic power_on();
    exp_q.push_back({1'b0, 8'h01});
    key_ligar = 1'b0;
    repeat (2) tick();
    check("verde_before_3cyc", LED_verde, 1'b0);
    tick();
    check("verde_at_3cyc", LED_verde, 1'b1);
    check("busy_init", busy, 1'b1);
    key_ligar = 1'b1;
    repeat (DELAY - 1) tick();
    check("lcd_e_before_clear", lcd_e, 1'b0);
    tick();
    check("lcd_e_clear", lcd_e, 1'b1);
    check("lcd_clear_data", lcd_data_bus, 8'h01);
    repeat (DELAY - 1) tick();
    check("busy_before_fetch", busy, 1'b1);
    tick();
    check("busy_fetch", busy, 1'b0);
    check("verde_fetch", LED_verde, 1'b1);
    repeat (3) tick();
  endtask

  task automatic submit(input string nm, input logic [17:0] instr, input logic [7:0] exp_lcd,
                        input int exp_lat, input bit chk_alu, input logic [2:0] e_op,
                        input logic [15:0] e_a, input logic [15:0] e_b);
    int n;
    exp_q.push_back({1'b1, exp_lcd});
    instruction_input = instr;
    key_enviar = 1'b0;
    repeat (4) tick();
    key_enviar = 1'b1;
    if (chk_alu) begin
      check({nm, "_alu_op"}, alu_op, e_op);
      check({nm, "_alu_a"}, alu_op_a, e_a);
      check({nm, "_alu_b"}, alu_op_b, e_b);
    end
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check({nm, "_latency"}, n, exp_lat);
    n = 0;
    while (lcd_e && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, dbg_state=%0d", dbg_state);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    key_ligar = 1'b1;
    key_enviar = 1'b1;
    instruction_input = '0;
    repeat (3) tick();
    check("rst_led_vermelho", LED_vermelho, 1'b1);
    check("rst_led_verde", LED_verde, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_lcd_e", lcd_e, 1'b0);
    check("rst_lcd_data", lcd_data_bus, 8'h00);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_rw", lcd_rw, 1'b0);
    check("rst_alu_op", alu_op, 3'b000);
    check("rst_alu_a", alu_op_a, 16'h0000);
    check("rst_alu_b", alu_op_b, 16'h0000);
    reset = 1'b1;
    repeat (3) tick();

    power_on();

    submit("load_r2_m5", enc_load(4'd2, 7'h7B), 8'hFB, 1, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("disp_r2", enc_disp(4'd2), 8'hFB, DELAY, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("load_r1_7", enc_load(4'd1, 7'h07), 8'h07, 1, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("load_r3_9", enc_load(4'd3, 7'h09), 8'h09, 1, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("add_r4", enc_r(3'b001, 4'd4, 4'd1, 4'd3), 8'h10, 2, 1'b1, 3'b001, 16'h0007, 16'h0009);
    submit("disp_r4", enc_disp(4'd4), 8'h10, DELAY, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("subi_r5", enc_i(3'b100, 4'd5, 4'd4, 7'h03), 8'h0D, 2, 1'b1, 3'b100, 16'h0010, 16'h0003);
    submit("muli_r6", enc_i(3'b101, 4'd6, 4'd1, 7'h7E), 8'hF2, 2, 1'b1, 3'b101, 16'h0007, 16'hFFFE);
    submit("addi_r7", enc_i(3'b010, 4'd7, 4'd2, 7'h01), 8'hFC, 2, 1'b1, 3'b010, 16'hFFFB, 16'h0001);
    submit("sub_r8", enc_r(3'b011, 4'd8, 4'd1, 4'd3), 8'hFE, 2, 1'b1, 3'b011, 16'h0007, 16'h0009);
    submit("disp_r6", enc_disp(4'd6), 8'hF2, DELAY, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("load_r15_p63", enc_load(4'd15, 7'h3F), 8'h3F, 1, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("load_r0_m64", enc_load(4'd0, 7'h40), 8'hC0, 1, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("add_r14", enc_r(3'b001, 4'd14, 4'd15, 4'd0), 8'hFF, 2, 1'b1, 3'b001, 16'h003F, 16'hFFC0);
    submit("clear", {3'b110, 15'b0}, 8'h43, DELAY, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("disp_r4_clr", enc_disp(4'd4), 8'h00, DELAY, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("disp_r15_clr", enc_disp(4'd15), 8'h00, DELAY, 1'b0, 3'b000, 16'h0, 16'h0);

    // ligar and enviar in the same cycle: power-off wins, nothing latched
    instruction_input = enc_r(3'b001, 4'd4, 4'd1, 4'd3);
    key_ligar = 1'b0;
    key_enviar = 1'b0;
    repeat (3) tick();
    check("dual_led_vermelho", LED_vermelho, 1'b1);
    check("dual_busy", busy, 1'b0);
    check("dual_led_verde", LED_verde, 1'b0);
    key_ligar = 1'b1;
    key_enviar = 1'b1;
    repeat (4) tick();
    check("dual_not_latched", alu_op, 3'b000);
    check("dual_still_off", LED_vermelho, 1'b1);

    power_on();
    submit("load_r10_3", enc_load(4'd10, 7'h03), 8'h03, 1, 1'b0, 3'b000, 16'h0, 16'h0);

    // reset asserted in the middle of a LOAD writeback
    exp_q.push_back({1'b1, 8'h05});
    instruction_input = enc_load(4'd9, 7'h05);
    key_enviar = 1'b0;
    repeat (4) tick();
    key_enviar = 1'b1;
    @(negedge clk);
    #1;
    check("wb_busy_before_rst", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_led_vermelho", LED_vermelho, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_lcd_e", lcd_e, 1'b0);
    check("midrst_lcd_data", lcd_data_bus, 8'h00);
    check("midrst_lcd_rs", lcd_rs, 1'b0);
    check("midrst_alu_op", alu_op, 3'b000);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();

    power_on();
    submit("disp_r10_rst", enc_disp(4'd10), 8'h00, DELAY, 1'b0, 3'b000, 16'h0, 16'h0);
    submit("disp_r9_rst", enc_disp(4'd9), 8'h00, DELAY, 1'b0, 3'b000, 16'h0, 16'h0);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
